// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller: arbitrates MEM (priority) and IF requests and
// turns each 1-4 byte access into byte cycles on a RAM port with one-cycle read latency.
module mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              MEME_in,
    input  logic              MEMrw_in,
    input  logic [ADDR_W-1:0] MEMAddr_in,
    input  logic [DATA_W-1:0] MEMData_in,
    input  logic [2:0]        MEMLen_in,
    input  logic              IFE_in,
    input  logic [ADDR_W-1:0] IFAddr_in,
    output logic              MC_busy_out,
    output logic              MEM_dataE_out,
    output logic              IF_dataE_out,
    output logic [DATA_W-1:0] MC_data_out,
    input  logic [7:0]        ram_din_in,
    output logic [7:0]        ram_dout_out,
    output logic [ADDR_W-1:0] ram_a_out,
    output logic              ram_wr_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [DATA_W-1:0] data, data_nxt;
    logic [2:0]        len, len_nxt;
    logic [2:0]        cnt, cnt_nxt, cnt_inc;
    logic              owner, owner_nxt;
    logic [1:0]        byte_sel;
    logic              busy_nxt, mem_de_nxt, if_de_nxt, wr_nxt;
    logic [DATA_W-1:0] rdata_nxt;
    logic [7:0]        dout_nxt;
    logic [ADDR_W-1:0] a_nxt;

    function automatic logic [2:0] norm_len(input logic [2:0] l);
        if (l == 3'd0) return 3'd1;
        if (l > 3'd4)  return 3'd4;
        return l;
    endfunction

    // cnt is the index of the byte address currently on the RAM port; during READ the
    // byte arriving now belongs to index cnt-1.
    assign cnt_inc  = cnt + 3'd1;
    assign byte_sel = cnt[1:0] - 2'd1;

    always_ff @(posedge clk_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (MEME_in)    state_nxt = MEMrw_in ? WRITE : READ;
                else if (IFE_in) state_nxt = READ;
            end
            READ:    if (cnt == len)     state_nxt = DONE;
            WRITE:   if (!(cnt_inc < len)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        addr_nxt   = addr;
        data_nxt   = data;
        len_nxt    = len;
        owner_nxt  = owner;
        cnt_nxt    = cnt;
        rdata_nxt  = MC_data_out;
        a_nxt      = '0;
        dout_nxt   = 8'd0;
        wr_nxt     = 1'b0;
        mem_de_nxt = 1'b0;
        if_de_nxt  = 1'b0;
        busy_nxt   = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (MEME_in) begin
                    addr_nxt  = MEMAddr_in;
                    data_nxt  = MEMData_in;
                    len_nxt   = norm_len(MEMLen_in);
                    owner_nxt = 1'b0;
                    cnt_nxt   = 3'd0;
                    rdata_nxt = '0;
                    a_nxt     = MEMAddr_in;
                    wr_nxt    = MEMrw_in;
                    dout_nxt  = MEMrw_in ? MEMData_in[7:0] : 8'd0;
                end else if (IFE_in) begin
                    addr_nxt  = IFAddr_in;
                    len_nxt   = 3'd4;
                    owner_nxt = 1'b1;
                    cnt_nxt   = 3'd0;
                    rdata_nxt = '0;
                    a_nxt     = IFAddr_in;
                end
            end
            READ: begin
                if (cnt != 3'd0) rdata_nxt[{byte_sel, 3'b000} +: 8] = ram_din_in;
                if (cnt == len) begin
                    mem_de_nxt = ~owner;
                    if_de_nxt  = owner;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc < len) a_nxt = addr + ADDR_W'(cnt_inc);
                end
            end
            WRITE: begin
                if (cnt_inc < len) begin
                    cnt_nxt  = cnt_inc;
                    a_nxt    = addr + ADDR_W'(cnt_inc);
                    dout_nxt = data[{cnt_inc[1:0], 3'b000} +: 8];
                    wr_nxt   = 1'b1;
                end else begin
                    mem_de_nxt = ~owner;
                    if_de_nxt  = owner;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            MC_busy_out   <= 1'b0;
            MEM_dataE_out <= 1'b0;
            IF_dataE_out  <= 1'b0;
            MC_data_out   <= '0;
            ram_a_out     <= '0;
            ram_dout_out  <= 8'd0;
            ram_wr_out    <= 1'b0;
            len           <= 3'd1;
            cnt           <= 3'd0;
            owner         <= 1'b0;
        end else begin
            MC_busy_out   <= busy_nxt;
            MEM_dataE_out <= mem_de_nxt;
            IF_dataE_out  <= if_de_nxt;
            MC_data_out   <= rdata_nxt;
            ram_a_out     <= a_nxt;
            ram_dout_out  <= dout_nxt;
            ram_wr_out    <= wr_nxt;
            len           <= len_nxt;
            cnt           <= cnt_nxt;
            owner         <= owner_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        addr <= addr_nxt;
        data <= data_nxt;
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM environment, per-cycle output trace, and a
// request-level reference model of memory contents and access timing.
module tb_mem_ctrl;

    localparam int TRN = 4096;

    logic        clk, rst;
    logic        meme, memrw, ife;
    logic [31:0] memaddr, memdata, ifaddr;
    logic [2:0]  memlen;
    logic        busy, mde, ide;
    logic [31:0] mcdata;
    logic [7:0]  ram_din, ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] tr_a    [TRN];
    logic        tr_wr   [TRN];
    logic [7:0]  tr_dout [TRN];
    logic        tr_mde  [TRN];
    logic        tr_ide  [TRN];
    logic        tr_busy [TRN];
    logic [31:0] tr_data [TRN];

    logic [7:0] ram [logic [31:0]];
    logic [7:0] mdl [logic [31:0]];

    mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_in(clk), .rst_in(rst),
        .MEME_in(meme), .MEMrw_in(memrw), .MEMAddr_in(memaddr), .MEMData_in(memdata),
        .MEMLen_in(memlen), .IFE_in(ife), .IFAddr_in(ifaddr),
        .MC_busy_out(busy), .MEM_dataE_out(mde), .IF_dataE_out(ide), .MC_data_out(mcdata),
        .ram_din_in(ram_din), .ram_dout_out(ram_dout), .ram_a_out(ram_a), .ram_wr_out(ram_wr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] mdl_rd(input logic [31:0] a);
        return mdl.exists(a) ? mdl[a] : init_byte(a);
    endfunction

    // Expected little-endian read value of n bytes from the reference memory.
    function automatic logic [31:0] mdl_word(input logic [31:0] a, input int n);
        logic [31:0] w = 32'd0;
        for (int i = 0; i < n; i++) w = w | (32'(mdl_rd(a + 32'(i))) << (8 * i));
        return w;
    endfunction

    function automatic int eff_len(input logic [2:0] l);
        if (l == 3'd0) return 1;
        if (l > 3'd4)  return 4;
        return int'(l);
    endfunction

    function automatic int ix(input int c);
        return (c < 0 || c >= TRN) ? 0 : c;
    endfunction

    always @(posedge clk) begin
        if (ram_wr) ram[ram_a] = ram_dout;
        ram_din <= ram_rd(ram_a);
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (cyc < TRN) begin
            tr_a[cyc]    = ram_a;
            tr_wr[cyc]   = ram_wr;
            tr_dout[cyc] = ram_dout;
            tr_mde[cyc]  = mde;
            tr_ide[cyc]  = ide;
            tr_busy[cyc] = busy;
            tr_data[cyc] = mcdata;
        end
    end

    task automatic preset(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        mdl[a] = b;
    endtask

    // Presents one request in cycle c0 and holds it until its dataE; de_cyc = -1 on timeout.
    task automatic issue(input bit is_if, input bit rw, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] l,
                         output int c0, output int de_cyc);
        @(negedge clk);
        c0 = cyc;
        de_cyc = -1;
        if (is_if) begin
            ife = 1'b1; ifaddr = a;
        end else begin
            meme = 1'b1; memrw = rw; memaddr = a; memdata = d; memlen = l;
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                memaddr = $urandom; memdata = $urandom; memlen = 3'($urandom);
                memrw = 1'($urandom); ifaddr = $urandom;
            end
            if (is_if ? ide : mde) begin
                de_cyc = cyc;
                meme = 1'b0;
                ife = 1'b0;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int c0, de;
        rst = 1'b0; meme = 1'b1; memrw = 1'b0; memaddr = 32'h40; memlen = 3'd4;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, mde, ide, mcdata, ram_a, ram_dout, ram_wr} !== 76'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: busy=%b mde=%b ide=%b data=%h a=%h dout=%h wr=%b, want all 0",
                         k, busy, mde, ide, mcdata, ram_a, ram_dout, ram_wr);
            end
        end
        c0 = cyc;
        rst = 1'b1;
        de = -1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_release_busy got %b want 1", busy); end
        checks++;
        if (ram_a !== 32'h40) begin errors++; $display("FAIL reset_release_addr got %h want 00000040", ram_a); end
        for (int k = 0; k < 40; k++) begin
            if (mde) begin de = cyc; meme = 1'b0; break; end
            @(negedge clk);
        end
        #1;
        checks++;
        if (de !== c0 + 6) begin errors++; $display("FAIL reset_release_latency got %0d want %0d", de, c0 + 6); end
        checks++;
        if (tr_data[ix(de)] !== mdl_word(32'h40, 4))
            begin errors++; $display("FAIL reset_release_data got %h want %h", tr_data[ix(de)], mdl_word(32'h40, 4)); end
    endtask

    task automatic test_word_read();
        int c0, de;
        preset(32'h100, 8'h11); preset(32'h101, 8'h22);
        preset(32'h102, 8'h33); preset(32'h103, 8'h44);
        issue(1'b0, 1'b0, 32'h100, 32'h0, 3'd4, c0, de);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tr_a[ix(c0 + 1 + i)] !== 32'h100 + 32'(i) || tr_wr[ix(c0 + 1 + i)] !== 1'b0) begin
                errors++;
                $display("FAIL word_read_addr%0d got a=%h wr=%b want a=%h wr=0",
                         i, tr_a[ix(c0 + 1 + i)], tr_wr[ix(c0 + 1 + i)], 32'h100 + 32'(i));
            end
        end
        checks++;
        if (de !== c0 + 6) begin errors++; $display("FAIL word_read_latency got %0d want %0d", de, c0 + 6); end
        checks++;
        if (tr_mde[ix(c0 + 5)] !== 1'b0 || tr_busy[ix(c0 + 6)] !== 1'b1)
            begin errors++; $display("FAIL word_read_pulse got mde5=%b busy6=%b want 0 1", tr_mde[ix(c0 + 5)], tr_busy[ix(c0 + 6)]); end
        checks++;
        if (tr_data[ix(de)] !== 32'h44332211)
            begin errors++; $display("FAIL word_read_data got %h want 44332211", tr_data[ix(de)]); end
        @(negedge clk);
        checks++;
        if (mde !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL word_read_after got mde=%b busy=%b want 0 0", mde, busy); end
    endtask

    task automatic test_half_write();
        int c0, de;
        issue(1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 3'd2, c0, de);
        mdl[32'h2000] = 8'hEF;
        mdl[32'h2001] = 8'hBE;
        checks++;
        if (tr_a[ix(c0 + 1)] !== 32'h2000 || tr_wr[ix(c0 + 1)] !== 1'b1 || tr_dout[ix(c0 + 1)] !== 8'hEF)
            begin errors++; $display("FAIL half_write_b0 got a=%h wr=%b d=%h want 00002000 1 ef", tr_a[ix(c0 + 1)], tr_wr[ix(c0 + 1)], tr_dout[ix(c0 + 1)]); end
        checks++;
        if (tr_a[ix(c0 + 2)] !== 32'h2001 || tr_wr[ix(c0 + 2)] !== 1'b1 || tr_dout[ix(c0 + 2)] !== 8'hBE)
            begin errors++; $display("FAIL half_write_b1 got a=%h wr=%b d=%h want 00002001 1 be", tr_a[ix(c0 + 2)], tr_wr[ix(c0 + 2)], tr_dout[ix(c0 + 2)]); end
        checks++;
        if (tr_wr[ix(c0 + 3)] !== 1'b0) begin errors++; $display("FAIL half_write_wr3 got %b want 0", tr_wr[ix(c0 + 3)]); end
        checks++;
        if (de !== c0 + 3) begin errors++; $display("FAIL half_write_latency got %0d want %0d", de, c0 + 3); end
        checks++;
        if (ram_rd(32'h2002) !== mdl_rd(32'h2002) || ram_rd(32'h2001) !== 8'hBE)
            begin errors++; $display("FAIL half_write_ram got 2001=%h 2002=%h want be %h", ram_rd(32'h2001), ram_rd(32'h2002), mdl_rd(32'h2002)); end
    endtask

    task automatic test_arbitration();
        int c0, mem_de, if_de;
        @(negedge clk);
        c0 = cyc;
        mem_de = -1; if_de = -1;
        meme = 1'b1; memrw = 1'b0; memaddr = 32'h300; memlen = 3'd1; memdata = 32'h0;
        ife = 1'b1; ifaddr = 32'h400;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (mde) begin mem_de = cyc; meme = 1'b0; end
            if (ide) begin if_de = cyc; ife = 1'b0; break; end
        end
        #1;
        checks++;
        if (mem_de !== c0 + 3) begin errors++; $display("FAIL arb_mem_latency got %0d want %0d", mem_de, c0 + 3); end
        checks++;
        if (tr_data[ix(mem_de)] !== mdl_word(32'h300, 1))
            begin errors++; $display("FAIL arb_mem_data got %h want %h", tr_data[ix(mem_de)], mdl_word(32'h300, 1)); end
        checks++;
        if (tr_busy[ix(c0 + 4)] !== 1'b0 || tr_a[ix(c0 + 5)] !== 32'h400)
            begin errors++; $display("FAIL arb_if_accept got busy4=%b a5=%h want 0 00000400", tr_busy[ix(c0 + 4)], tr_a[ix(c0 + 5)]); end
        checks++;
        if (if_de !== c0 + 10) begin errors++; $display("FAIL arb_if_latency got %0d want %0d", if_de, c0 + 10); end
        checks++;
        if (tr_data[ix(if_de)] !== mdl_word(32'h400, 4) || tr_mde[ix(if_de)] !== 1'b0)
            begin errors++; $display("FAIL arb_if_data got %h mde=%b want %h 0", tr_data[ix(if_de)], tr_mde[ix(if_de)], mdl_word(32'h400, 4)); end
    endtask

    task automatic test_wrap();
        int c0, de;
        logic [31:0] exp_a [4];
        exp_a[0] = 32'hFFFFFFFE; exp_a[1] = 32'hFFFFFFFF; exp_a[2] = 32'h0; exp_a[3] = 32'h1;
        preset(exp_a[0], 8'hA1); preset(exp_a[1], 8'hB2);
        preset(exp_a[2], 8'hC3); preset(exp_a[3], 8'hD4);
        issue(1'b1, 1'b0, 32'hFFFFFFFE, 32'h0, 3'd4, c0, de);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tr_a[ix(c0 + 1 + i)] !== exp_a[i])
                begin errors++; $display("FAIL wrap_addr%0d got %h want %h", i, tr_a[ix(c0 + 1 + i)], exp_a[i]); end
        end
        checks++;
        if (de !== c0 + 6 || tr_data[ix(de)] !== 32'hD4C3B2A1)
            begin errors++; $display("FAIL wrap_data got cyc=%0d data=%h want %0d d4c3b2a1", de, tr_data[ix(de)], c0 + 6); end
    endtask

    task automatic test_reset_mid();
        int c0, de, pulses;
        @(negedge clk);
        c0 = cyc;
        meme = 1'b1; memrw = 1'b0; memaddr = 32'h100; memlen = 3'd4;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        meme = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ram_a !== 32'h0 || mcdata !== 32'h0)
            begin errors++; $display("FAIL midreset_state got busy=%b a=%h data=%h want 0 0 0", busy, ram_a, mcdata); end
        rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mde || ide || busy) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL midreset_no_pulse got %0d active cycles want 0", pulses); end
        issue(1'b1, 1'b0, 32'h100, 32'h0, 3'd4, c0, de);
        checks++;
        if (de !== c0 + 6 || tr_data[ix(de)] !== mdl_word(32'h100, 4))
            begin errors++; $display("FAIL midreset_if got cyc=%0d data=%h want %0d %h", de, tr_data[ix(de)], c0 + 6, mdl_word(32'h100, 4)); end
    endtask

    task automatic test_random();
        int c0, de, n;
        bit is_if, rw;
        logic [31:0] a, d, exp;
        logic [2:0] l;
        for (int t = 0; t < 30; t++) begin
            is_if = ($urandom_range(0, 3) == 0);
            rw = is_if ? 1'b0 : 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                             : 32'h5000 + 32'($urandom_range(0, 15));
            d = $urandom;
            l = 3'($urandom_range(0, 7));
            n = is_if ? 4 : eff_len(l);
            exp = mdl_word(a, n);
            issue(is_if, rw, a, d, l, c0, de);
            for (int i = 0; i < n; i++) begin
                checks++;
                if (tr_a[ix(c0 + 1 + i)] !== a + 32'(i) || tr_wr[ix(c0 + 1 + i)] !== rw ||
                    (rw && tr_dout[ix(c0 + 1 + i)] !== d[8 * i +: 8])) begin
                    errors++;
                    $display("FAIL rand%0d_byte%0d got a=%h wr=%b d=%h want a=%h wr=%b d=%h", t, i,
                             tr_a[ix(c0 + 1 + i)], tr_wr[ix(c0 + 1 + i)], tr_dout[ix(c0 + 1 + i)],
                             a + 32'(i), rw, rw ? d[8 * i +: 8] : 8'h00);
                end
                if (rw) mdl[a + 32'(i)] = d[8 * i +: 8];
            end
            checks++;
            if (de !== c0 + n + (rw ? 1 : 2))
                begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", t, de, c0 + n + (rw ? 1 : 2)); end
            checks++;
            if ((is_if ? tr_mde[ix(de)] : tr_ide[ix(de)]) !== 1'b0)
                begin errors++; $display("FAIL rand%0d_owner other requester pulsed, want 0", t); end
            checks++;
            if (!rw && tr_data[ix(de)] !== exp)
                begin errors++; $display("FAIL rand%0d_data got %h want %h", t, tr_data[ix(de)], exp); end
            checks++;
            if (rw && (ram_rd(a) !== mdl_rd(a) || ram_rd(a + 32'(n)) !== mdl_rd(a + 32'(n))))
                begin errors++; $display("FAIL rand%0d_ram got %h %h want %h %h", t, ram_rd(a), ram_rd(a + 32'(n)), mdl_rd(a), mdl_rd(a + 32'(n))); end
        end
    endtask

    initial begin
        rst = 1'b0; meme = 1'b0; memrw = 1'b0; ife = 1'b0;
        memaddr = 32'h0; memdata = 32'h0; memlen = 3'd0; ifaddr = 32'h0;
        test_reset();
        test_word_read();
        test_half_write();
        test_arbitration();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
